rotary_quad_tx: RTL and testbench



---
 rtl/rotary_quad_tx_pkg.sv | 39 +++
 rtl/rotary_quad_tx_if.sv | 36 +++
 rtl/rotary_quad_tx_phase_timer.sv | 29 ++
 rtl/rotary_quad_tx.sv | 151 +++++++++++++++
 tb/tb_rotary_quad_tx.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/rotary_quad_tx_pkg.sv
// Shared types and phase tables for the rotary quadrature transmitter.
// A/B values are packed as {A,B}.
package rotary_quad_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_S1   = 3'd1,
    ST_S2   = 3'd2,
    ST_S3   = 3'd3,
    ST_GAP  = 3'd4
  } state_t;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  localparam logic [1:0] AB_REST = 2'b00;
  localparam logic [1:0] AB_R_S1 = 2'b10;
  localparam logic [1:0] AB_R_S2 = 2'b11;
  localparam logic [1:0] AB_R_S3 = 2'b01;
  localparam logic [1:0] AB_L_S1 = 2'b01;
  localparam logic [1:0] AB_L_S2 = 2'b11;
  localparam logic [1:0] AB_L_S3 = 2'b10;

  function automatic logic [1:0] ab_of(
    input state_t s,
    input logic   dir
  );
    logic [1:0] ab;
    ab = AB_REST;
    case (s)
      ST_S1:   ab = (dir == DIR_LEFT) ? AB_L_S1 : AB_R_S1;
      ST_S2:   ab = (dir == DIR_LEFT) ? AB_L_S2 : AB_R_S2;
      ST_S3:   ab = (dir == DIR_LEFT) ? AB_L_S3 : AB_R_S3;
      default: ab = AB_REST;
    endcase
    return ab;
  endfunction

endpackage

// File: rtl/rotary_quad_tx_if.sv
// Step-request and quadrature-output bundle of the rotary transmitter.
// The stimulus side is the master; the transmitter is the slave.
interface rotary_quad_tx_if #(
  parameter int CNT_W = 4
);
  logic                    EV;
  logic                    IZ;
  logic                    ROTA;
  logic                    ROTB;
  logic                    BUSY;
  logic                    STEP_DONE;
  logic                    OVF;
  logic signed [CNT_W-1:0] PEND;

  modport master (
    output EV,
    output IZ,
    input  ROTA,
    input  ROTB,
    input  BUSY,
    input  STEP_DONE,
    input  OVF,
    input  PEND
  );

  modport slave (
    input  EV,
    input  IZ,
    output ROTA,
    output ROTB,
    output BUSY,
    output STEP_DONE,
    output OVF,
    output PEND
  );
endinterface

// File: rtl/rotary_quad_tx_phase_timer.sv
// Loadable down-counter timing each A/B phase.
// phase_end is high during the last cycle of a phase.
module rotary_phase_timer #(
  parameter int PHASE_CYCLES = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_run,
  output logic o_phase_end
);
  localparam int TW =
    (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;

  logic [TW-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= TW'(PHASE_CYCLES - 1);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - TW'(1);
    end
  end

  assign o_phase_end = i_run && (r_cnt == '0);

endmodule

// File: rtl/rotary_quad_tx.sv
// Quadrature transmitter: step requests become full A/B detent cycles.
// Holds the pending-step counter, the phase FSM and the output registers.
module rotary_quad_tx
  import rotary_quad_tx_pkg::*;
#(
  parameter int PHASE_CYCLES = 4,
  parameter int CNT_W        = 4
) (
  input  logic CLK,
  input  logic RST,
  rotary_quad_tx_if.slave bus
);
  localparam logic signed [CNT_W:0] MAXV =
    (CNT_W+1)'((1 << (CNT_W - 1)) - 1);

  state_t r_state;
  state_t w_state_nx;
  logic   r_dir;
  logic   w_dir_nx;
  logic   r_a;
  logic   r_b;
  logic   r_done;
  logic   w_done_nx;
  logic   r_ovf;
  logic   w_ovf_nx;
  logic   w_load;
  logic   w_run;
  logic   w_phase_end;
  logic   w_has_pend;
  logic   w_start;
  logic   w_sign;
  logic [1:0] w_ab;

  logic signed [CNT_W-1:0] r_pend;
  logic signed [CNT_W-1:0] w_pend_nx;
  logic signed [CNT_W:0]   w_req;
  logic signed [CNT_W:0]   w_take;
  logic signed [CNT_W:0]   w_base;
  logic signed [CNT_W:0]   w_sum;

  assign w_run      = (r_state != ST_IDLE);
  assign w_has_pend = (r_pend != '0);
  assign w_sign     = r_pend[CNT_W-1];
  assign w_start    = w_has_pend &&
                      ((r_state == ST_IDLE) ||
                       ((r_state == ST_GAP) && w_phase_end));

  rotary_phase_timer #(
    .PHASE_CYCLES(PHASE_CYCLES)
  ) u_timer (
    .i_clk      (CLK),
    .i_rst      (RST),
    .i_load     (w_load),
    .i_run      (w_run),
    .o_phase_end(w_phase_end)
  );

  // Take comes off first so a request that fits after it is kept.
  always_comb begin
    w_req = '0;
    if (bus.EV) begin
      w_req = bus.IZ ? '1 : (CNT_W+1)'(1);
    end
    w_take = '0;
    if (w_start) begin
      w_take = w_sign ? '1 : (CNT_W+1)'(1);
    end
    w_base    = $signed({w_sign, r_pend}) - w_take;
    w_sum     = w_base + w_req;
    w_ovf_nx  = (w_req != '0) &&
                ((w_sum > MAXV) || (w_sum < -MAXV));
    w_pend_nx = w_ovf_nx ? w_base[CNT_W-1:0]
                         : w_sum[CNT_W-1:0];
  end

  always_comb begin
    w_state_nx = r_state;
    w_dir_nx   = r_dir;
    w_load     = 1'b0;
    w_done_nx  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_nx = ST_S1;
          w_dir_nx   = w_sign ? DIR_LEFT : DIR_RIGHT;
          w_load     = 1'b1;
        end
      end
      ST_S1: begin
        if (w_phase_end) begin
          w_state_nx = ST_S2;
          w_load     = 1'b1;
        end
      end
      ST_S2: begin
        if (w_phase_end) begin
          w_state_nx = ST_S3;
          w_load     = 1'b1;
        end
      end
      ST_S3: begin
        if (w_phase_end) begin
          w_state_nx = ST_GAP;
          w_load     = 1'b1;
          w_done_nx  = 1'b1;
        end
      end
      ST_GAP: begin
        if (w_start) begin
          w_state_nx = ST_S1;
          w_dir_nx   = w_sign ? DIR_LEFT : DIR_RIGHT;
          w_load     = 1'b1;
        end else if (w_phase_end) begin
          w_state_nx = ST_IDLE;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
    w_ab = ab_of(w_state_nx, w_dir_nx);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_dir   <= DIR_RIGHT;
      r_a     <= 1'b0;
      r_b     <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
      r_pend  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_dir   <= w_dir_nx;
      r_a     <= w_ab[1];
      r_b     <= w_ab[0];
      r_done  <= w_done_nx;
      r_ovf   <= w_ovf_nx;
      r_pend  <= w_pend_nx;
    end
  end

  assign bus.ROTA      = r_a;
  assign bus.ROTB      = r_b;
  assign bus.BUSY      = w_run;
  assign bus.STEP_DONE = r_done;
  assign bus.OVF       = r_ovf;
  assign bus.PEND      = r_pend;

endmodule

// File: tb/tb_rotary_quad_tx.sv
// Bench for rotary_quad_tx: directed scenarios plus random requests,
// every cycle compared with a step-schedule reference model.
module tb_rotary_quad_tx;
  localparam int PC   = 4;
  localparam int CW   = 4;
  localparam int MAXP = 7;

  logic CLK = 1'b0;
  logic RST;

  rotary_quad_tx_if #(.CNT_W(CW)) bus ();

  rotary_quad_tx #(
    .PHASE_CYCLES(PC),
    .CNT_W       (CW)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  int   total = 0;
  int   bad   = 0;
  int   m_pend;
  int   m_start;
  int   m_e;
  logic m_dir;
  logic m_ovf;

  task automatic chk(
    input string              tag,
    input logic signed [31:0] obs,
    input logic signed [31:0] exp
  );
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d t=%0t",
               tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_active();
    return (m_start >= 0) && (m_e - m_start < 4*PC);
  endfunction

  function automatic int m_phase();
    return m_active() ? (m_e - m_start) / PC : -1;
  endfunction

  function automatic bit m_will_start();
    return ((m_start < 0) || (m_e + 1 >= m_start + 4*PC))
           && (m_pend != 0);
  endfunction

  task automatic model_reset();
    m_pend  = 0;
    m_start = -1;
    m_ovf   = 1'b0;
    m_dir   = 1'b0;
  endtask

  task automatic model_edge(input logic ev, input logic iz);
    int req;
    int take;
    int base;
    int s;
    bit can;
    m_e++;
    can  = ((m_start < 0) || (m_e >= m_start + 4*PC))
           && (m_pend != 0);
    req  = ev ? (iz ? -1 : 1) : 0;
    take = can ? ((m_pend > 0) ? 1 : -1) : 0;
    if (can) begin
      m_start = m_e;
      m_dir   = (m_pend < 0);
    end
    base  = m_pend - take;
    s     = base + req;
    m_ovf = (s > MAXP) || (s < -MAXP);
    m_pend = m_ovf ? base : s;
  endtask

  task automatic check_all();
    logic [1:0] ab;
    logic       busy;
    logic       done;
    ab   = 2'b00;
    busy = 1'b0;
    done = 1'b0;
    if (m_active()) begin
      busy = 1'b1;
      done = (m_e - m_start == 3*PC);
      case (m_phase())
        0:       ab = m_dir ? 2'b01 : 2'b10;
        1:       ab = 2'b11;
        2:       ab = m_dir ? 2'b10 : 2'b01;
        default: ab = 2'b00;
      endcase
    end
    chk("rota", 32'(bus.ROTA), 32'(ab[1]));
    chk("rotb", 32'(bus.ROTB), 32'(ab[0]));
    chk("busy", 32'(bus.BUSY), 32'(busy));
    chk("done", 32'(bus.STEP_DONE), 32'(done));
    chk("ovf",  32'(bus.OVF), 32'(m_ovf));
    chk("pend", 32'(bus.PEND), m_pend);
  endtask

  task automatic cyc(input logic ev, input logic iz);
    bus.EV = ev;
    bus.IZ = iz;
    @(posedge CLK);
    model_edge(ev, iz);
    #1;
    check_all();
    bus.EV = 1'b0;
    bus.IZ = 1'b0;
  endtask

  task automatic do_reset();
    #3;
    RST = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge CLK);
    #4;
    RST = 1'b0;
  endtask

  initial begin
    int k;
    RST    = 1'b0;
    bus.EV = 1'b0;
    bus.IZ = 1'b0;
    m_e    = 0;
    model_reset();
    do_reset();

    // single right step
    cyc(1'b1, 1'b0);
    repeat (20) cyc(1'b0, 1'b0);

    // three left back-to-back
    repeat (3) cyc(1'b1, 1'b1);
    repeat (52) cyc(1'b0, 1'b0);

    // cancel during S2
    cyc(1'b1, 1'b0);
    k = 0;
    while (m_phase() != 1 && k < 30) begin
      cyc(1'b0, 1'b0);
      k++;
    end
    chk("tmo_cancel", 32'(m_phase()), 32'd1);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    repeat (30) cyc(1'b0, 1'b0);

    // saturation, then left at a take
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    repeat (9) cyc(1'b1, 1'b0);
    chk("sat_pend", 32'(bus.PEND), 32'sd7);
    k = 0;
    while (!m_will_start() && k < 40) begin
      cyc(1'b0, 1'b0);
      k++;
    end
    chk("tmo_sat", 32'(m_will_start()), 32'd1);
    cyc(1'b1, 1'b1);
    chk("take_pend", 32'(bus.PEND), 32'sd5);
    chk("take_ovf", 32'(bus.OVF), 32'd0);
    repeat (110) cyc(1'b0, 1'b0);

    // reset mid-step in S2
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    k = 0;
    while (m_phase() != 1 && k < 30) begin
      cyc(1'b0, 1'b0);
      k++;
    end
    chk("tmo_rst", 32'(m_phase()), 32'd1);
    do_reset();
    cyc(1'b1, 1'b0);
    repeat (20) cyc(1'b0, 1'b0);

    // random requests
    repeat (800) begin
      cyc($urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)));
    end
    repeat (130) cyc(1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
